// File: rtl/ifetch_pkg.sv
// Shared types for the instruction prefetch queue.
// No logic here, so no latency.
// No handshake; types and constants only.
package ifetch_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_FLUSH
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of {pc, instr} entries with a synchronous flush.
// Latency: a push is visible at the head one cycle later.
// Backpressure: the caller never pushes when full; a pop while empty is ignored.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  entry_t                       push_dat,
   input  logic                         pop,
   output logic                         head_vld,
   output entry_t                       head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic               pop_ok;

   assign pop_ok   = pop && (count != '0);
   assign head_vld = (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // A flush may coincide with a push of the reuse word; it becomes the only entry.
         rd_ptr <= '0;
         wr_ptr <= push ? PTR_W'(1) : '0;
         count  <= push ? CNT_W'(1) : '0;
         if (push) mem[0] <= push_dat;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch queue in front of the SPI program memory; IFETCH_PERF_EN adds fetch/discard counters.
// Latency: a word returned on mem_ready appears at fetch_* the next cycle.
// Backpressure: fetches stop while the queue is full; redirects flush and may discard an in-flight word.
module ifetch_prefetch
   import ifetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_instruction,
   input  logic              mem_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic [ADDR_W-1:0] fetch_pc,
   input  logic              fetch_accept,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetches,
   output logic [15:0]       perf_discards
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   state_t             state;
   logic [ADDR_W-1:0]  pend_pc;
   logic [ADDR_W-1:0]  reuse_addr;
   logic [DATA_W-1:0]  reuse_instr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   post_cnt;
   logic [ADDR_W-1:0]  tgt;
   logic               done;
   logic               resolve;
   logic               hit;
   logic               push;
   logic               pop;
   entry_t             push_dat;
   entry_t             head_dat;
   logic               head_vld;

   // "resolve" marks every cycle where a redirect target is settled with no fetch left in flight.
   always_comb begin
      done     = mem_ready && (state != S_IDLE);
      pop      = fetch_accept && head_vld && !redirect;
      tgt      = (state == S_FLUSH && !redirect) ? pend_pc : redirect_pc;
      hit      = done ? (tgt == mem_address) : (tgt == reuse_addr);
      resolve  = (redirect && (state == S_IDLE || done)) || (state == S_FLUSH && done);
      push_dat = '{pc: done ? mem_address : reuse_addr,
                   instr: done ? mem_instruction : reuse_instr};
      push     = 1'b0;
      if (resolve)                    push = hit;
      else if (state == S_BUSY && done) push = 1'b1;
      post_cnt = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_BUSY;
         mem_address <= RESET_PC;
         pend_pc     <= '0;
         reuse_addr  <= 16'hFFFF;
         reuse_instr <= '0;
      end else begin
         if (done) begin
            reuse_addr  <= mem_address;
            reuse_instr <= mem_instruction;
         end
         if (resolve) begin
            if (hit) begin
               state <= S_IDLE;
            end else begin
               mem_address <= tgt;
               state       <= S_BUSY;
            end
         end else if (redirect) begin
            // A busy fetch of the redirect target itself is kept; anything else must drain first.
            if (state == S_FLUSH || redirect_pc != mem_address) begin
               pend_pc <= redirect_pc;
               state   <= S_FLUSH;
            end
         end else if (state == S_BUSY && done) begin
            if (post_cnt < CNT_W'(DEPTH)) mem_address <= mem_address + PC_STEP;
            else                          state       <= S_IDLE;
         end else if (state == S_IDLE && count < CNT_W'(DEPTH)) begin
            mem_address <= mem_address + PC_STEP;
            state       <= S_BUSY;
         end
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetches  <= '0;
         perf_discards <= '0;
      end else begin
         if (done && perf_fetches != 16'hFFFF) perf_fetches <= perf_fetches + 16'd1;
         if (done && (redirect || state == S_FLUSH) && perf_discards != 16'hFFFF)
            perf_discards <= perf_discards + 16'd1;
      end
   end
`endif

   ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_vld (head_vld),
      .head_dat (head_dat),
      .count    (count)
   );

   assign fetch_valid = head_vld;
   assign fetch_pc    = head_dat.pc;
   assign fetch_instr = head_dat.instr;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: memory model with random latency, stream-order reference, directed scenarios then random redirects/accepts.
module tb_ifetch_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_address;
   logic [15:0] mem_instruction;
   logic        mem_ready;
   logic        fetch_valid;
   logic [15:0] fetch_instr;
   logic [15:0] fetch_pc;
   logic        fetch_accept;
   logic        redirect;
   logic [15:0] redirect_pc;
`ifdef IFETCH_PERF_EN
   logic [15:0] perf_fetches;
   logic [15:0] perf_discards;
`endif

   always #5 clk = ~clk;

   ifetch_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_address     (mem_address),
      .mem_instruction (mem_instruction),
      .mem_ready       (mem_ready),
      .fetch_valid     (fetch_valid),
      .fetch_instr     (fetch_instr),
      .fetch_pc        (fetch_pc),
      .fetch_accept    (fetch_accept),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetches    (perf_fetches),
      .perf_discards   (perf_discards)
`endif
   );

   int          total = 0;
   int          bad   = 0;

   // memory model and stream reference
   bit          mem_busy  = 0;
   logic [15:0] fa        = '0;
   logic [15:0] last_done = 16'hFFFF;
   int          lat       = 0;
   bit          stale     = 0;
   int          n_fetch   = 0;
   int          n_disc    = 0;
   logic [15:0] starts[$];
   logic [15:0] pops[$];
   logic [15:0] exp_pc    = 16'h0000;
   bit          chk_redir = 0;
   bit          exp_hit   = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One negedge: check what the last posedge produced, then step the memory.
   task automatic advance();
      @(negedge clk);
      if (chk_redir) begin
         chk("redir_vld", 16'(fetch_valid), 16'(exp_hit));
         chk_redir = 0;
      end
      if (fetch_valid) begin
         chk("head_pc", fetch_pc, exp_pc);
         chk("head_instr", fetch_instr, exp_pc ^ 16'hA5A5);
      end
      mem_ready       = 1'b0;
      mem_instruction = 16'($urandom);
      if (!rst) begin
         mem_busy  = 0;
         last_done = 16'hFFFF;
      end else if (mem_busy) begin
         chk("mem_hold", mem_address, fa);
         lat--;
         if (lat == 0) begin
            mem_ready       = 1'b1;
            mem_instruction = fa ^ 16'hA5A5;
            last_done       = fa;
            mem_busy        = 0;
            n_fetch++;
         end
      end else if (mem_address != last_done) begin
         mem_busy = 1;
         fa       = mem_address;
         lat      = $urandom_range(1, 3);
         stale    = 0;
         starts.push_back(fa);
      end
   endtask

   task automatic drive(input logic acc, input logic rd, input logic [15:0] tgt);
      fetch_accept = acc;
      redirect     = rd;
      redirect_pc  = tgt;
      if (mem_ready && (rd || stale)) n_disc++;
      if (rd) begin
         // Reuse only when nothing stays in flight and the target is the word just held.
         exp_hit   = !mem_busy && (tgt == last_done);
         chk_redir = 1;
         if (mem_busy && tgt != fa) stale = 1;
         exp_pc = tgt;
      end else if (acc && fetch_valid) begin
         pops.push_back(fetch_pc);
         exp_pc = exp_pc + 16'd2;
      end
   endtask

   task automatic wait_start(input int idx, output bit ok);
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin
         advance();
         drive(1'b0, 1'b0, 16'h0);
         if (starts.size() > idx) ok = 1;
      end
   endtask

   initial begin
      int          idx;
      bit          ok;
      logic [15:0] t;
      rst = 1'b0; fetch_accept = 0; redirect = 0; redirect_pc = '0;
      mem_ready = 0; mem_instruction = '0;
      repeat (2) @(negedge clk);
      chk("rst_vld", 16'(fetch_valid), 16'd0);
      chk("rst_pc", fetch_pc, 16'h0000);
      chk("rst_instr", fetch_instr, 16'h0000);
      chk("rst_addr", mem_address, 16'h0000);
      rst = 1'b1;

      // fill with no accepts: fetches 0,2,4,6 then idle
      repeat (60) begin advance(); drive(1'b0, 1'b0, 16'h0); end
      chk("fill_nstart", 16'(starts.size()), 16'd4);
      chk("fill_last", starts[$], 16'h0006);
      chk("fill_addr", mem_address, 16'h0006);
      chk("fill_idle", 16'(mem_busy), 16'd0);
      chk("fill_head", fetch_pc, 16'h0000);

      // one accept frees one slot: exactly one fetch at 8
      advance(); drive(1'b1, 1'b0, 16'h0);
      repeat (40) begin advance(); drive(1'b0, 1'b0, 16'h0); end
      chk("one_nstart", 16'(starts.size()), 16'd5);
      chk("one_last", starts[$], 16'h0008);

      // redirect to 0100 while a fetch is in flight
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin
         advance();
         if (mem_busy) begin drive(1'b0, 1'b1, 16'h0100); ok = 1; end
         else drive(1'b1, 1'b0, 16'h0);
      end
      chk("mid_found", 16'(ok), 16'd1);
      idx = starts.size();
      wait_start(idx, ok);
      chk("mid_next", ok ? starts[idx] : 16'hDEAD, 16'h0100);
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
         advance(); drive(1'b0, 1'b0, 16'h0);
         ok = fetch_valid;
      end
      chk("mid_head", fetch_pc, 16'h0100);

      // reuse hit while idle: no refetch, next fetch is the following word
      repeat (60) begin advance(); drive(1'b0, 1'b0, 16'h0); end
      chk("reuse_idle", 16'(mem_busy), 16'd0);
      t   = last_done;
      idx = starts.size();
      advance(); drive(1'b0, 1'b1, t);
      advance(); drive(1'b0, 1'b0, 16'h0);
      chk("reuse_vld", 16'(fetch_valid), 16'd1);
      chk("reuse_pc", fetch_pc, t);
      chk("reuse_instr", fetch_instr, t ^ 16'hA5A5);
      wait_start(idx, ok);
      chk("reuse_next", ok ? starts[idx] : 16'hDEAD, t + 16'd2);

      // redirect together with mem_ready and accept
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin
         advance();
         if (mem_ready) begin drive(1'b1, 1'b1, 16'h0200); ok = 1; end
         else drive(1'b1, 1'b0, 16'h0);
      end
      chk("coin_found", 16'(ok), 16'd1);
      idx = starts.size();
      advance(); drive(1'b0, 1'b0, 16'h0);
      chk("coin_empty", 16'(fetch_valid), 16'd0);
      wait_start(idx, ok);
      chk("coin_next", ok ? starts[idx] : 16'hDEAD, 16'h0200);

      // wrap at FFFE with continuous accept
      advance(); drive(1'b1, 1'b1, 16'hFFFE);
      pops.delete();
      for (int c = 0; c < 100 && pops.size() < 3; c++) begin
         advance(); drive(1'b1, 1'b0, 16'h0);
      end
      chk("wrap_n", 16'(pops.size() >= 3), 16'd1);
      if (pops.size() >= 3) begin
         chk("wrap_0", pops[0], 16'hFFFE);
         chk("wrap_1", pops[1], 16'h0000);
         chk("wrap_2", pops[2], 16'h0002);
      end

      // random accepts and redirects
      pops.delete();
      for (int c = 0; c < 3000; c++) begin
         advance();
         if ($urandom_range(0, 99) < 4) begin
            case ($urandom_range(0, 3))
               0:       t = last_done;
               1:       t = fa;
               2:       t = 16'($urandom) & 16'hFFFE;
               default: t = 16'hFFF8 + 16'(2 * $urandom_range(0, 3));
            endcase
            drive(1'($urandom_range(0, 1)), 1'b1, t);
         end else begin
            drive($urandom_range(0, 2) != 0, 1'b0, 16'h0);
         end
      end
      chk("progress", 16'(pops.size() > 200), 16'd1);

      advance(); drive(1'b0, 1'b0, 16'h0);
      @(negedge clk);
`ifdef IFETCH_PERF_EN
      chk("perf_fetches", perf_fetches, 16'(n_fetch));
      chk("perf_discards", perf_discards, 16'(n_disc));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
